pipe_delay_line: RTL

- Parametrised elastic delay line for the pipelined FP adder datapath.
- Replaces fixed single-bit seven-flop delay chains used to align control/side-band bits with arithmetic stages.
- Carries WIDTH-bit payload through DEPTH register stages with per-stage valid, valid/ready back-pressure, bubble collapsing, synchronous flush and an occupancy count.

---
 rtl/fp_pipe_pkg.sv | 15 +
 rtl/pipe_stage.sv | 53 +++++
 rtl/pipe_delay_line.sv | 100 ++++++++++
 3 files changed

// File: rtl/fp_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pipe_pkg
// Purpose  : Shared helpers for the FP-adder pipeline blocks.
// Revision : 1.0 - initial release
// ============================================================================
package fp_pipe_pkg;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : fp_pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage
// Purpose  : One payload + valid register of the elastic delay line.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage #(
    parameter int WIDTH      = 1,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             ld_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             v_i,
    output logic [WIDTH-1:0] d_o,
    output logic             v_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Flush outranks load; payload is only wiped when CLEAR_DATA is set.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
            if (CLEAR_DATA) begin
                data_d = '0;
            end
        end else if (ld_i) begin
            data_d  = d_i;
            valid_d = v_i;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign d_o = data_q;
    assign v_o = valid_q;

endmodule : pipe_stage
`default_nettype wire

// File: rtl/pipe_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : pipe_delay_line
// Purpose  : Elastic DEPTH-stage delay line with back-pressure, bubble
//            collapsing, synchronous flush and occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_delay_line
    import fp_pipe_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int DEPTH      = 7,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic                         clk,
    input  logic                         clear_n,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         flush,
    output logic [cnt_width(DEPTH)-1:0]  count
);

    localparam int CW = cnt_width(DEPTH);

    logic [DEPTH-1:0] w_ld;
    logic [DEPTH-1:0] w_v;
    logic [WIDTH-1:0] w_s [DEPTH];
    logic             w_accept;
    logic             w_emit;
    logic [CW-1:0]    count_q, count_d;

    // A stage loads when it is empty or everything downstream of it moves.
    always_comb begin
        w_ld            = '0;
        w_ld[DEPTH-1]   = ~w_v[DEPTH-1] | out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            w_ld[k] = ~w_v[k] | w_ld[k+1];
        end
    end

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            logic [WIDTH-1:0] w_d_in;
            logic             w_v_in;

            if (k == 0) begin : g_head
                assign w_d_in = in_data;
                assign w_v_in = in_valid & ~flush;
            end else begin : g_body
                assign w_d_in = w_s[k-1];
                assign w_v_in = w_v[k-1];
            end

            pipe_stage #(
                .WIDTH      (WIDTH),
                .CLEAR_DATA (CLEAR_DATA)
            ) u_stage (
                .clk     (clk),
                .clear_n (clear_n),
                .ld_i    (w_ld[k]),
                .flush_i (flush),
                .d_i     (w_d_in),
                .v_i     (w_v_in),
                .d_o     (w_s[k]),
                .v_o     (w_v[k])
            );
        end
    endgenerate

    assign in_ready  = w_ld[0] & ~flush;
    assign out_data  = w_s[DEPTH-1];
    assign out_valid = w_v[DEPTH-1];
    assign w_accept  = in_valid & in_ready;
    assign w_emit    = out_valid & out_ready;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(w_accept) - CW'(w_emit);
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : pipe_delay_line
`default_nettype wire
